// File: rtl/gpio_out_ctrl.sv
// gpio_out_ctrl
//   Buffers processor GPIO writes in a small circular FIFO and shows each
//   buffered value on the board LED/display bus for at least HOLD_CYCLES+1
//   clk cycles. This keeps fast write bursts visible. A write that arrives
//   while the FIFO is full and nothing is popped is dropped, and the sticky
//   overflow flag is set.
//
//   Optional build macro: GPIO_EDGE_DETECT_EN
//     defined   - push only on a 0->1 transition of we_gpio_i, so a strobe
//                 held high for several clk cycles counts as one store
//     undefined - every clk edge with we_gpio_i high is a push request
//
// Ports
//   clk            in   board clock, rising edge
//   rst            in   asynchronous, active-high reset
//   gpio_i         in   write data from the processor top
//   we_gpio_i      in   write strobe from the processor top
//   clr_overflow_i in   clears overflow_o; a drop in the same cycle wins
//   led_o          out  displayed value
//   led_valid_o    out  led_o has been loaded at least once since reset
//   fifo_count_o   out  number of entries currently buffered
//   overflow_o     out  sticky flag, set when a write was dropped
//   busy_o         out  FSM is not IDLE
//
// FSM states
//   state  | meaning
//   IDLE   | nothing to show, waiting for the FIFO to become non-empty
//   LOAD   | move the FIFO head to led_o, pop it, start the hold timer
//   HOLD   | timer counts down to 0, then go to LOAD or IDLE
module gpio_out_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         gpio_i,
  input  logic                          we_gpio_i,
  input  logic                          clr_overflow_i,
  output logic [DATA_WIDTH-1:0]         led_o,
  output logic                          led_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o,
  output logic                          busy_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  // Keep the timer at least 1 bit wide when HOLD_CYCLES is 1.
  localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                state;
  logic [TMR_W-1:0]      tmr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic push_req;
  logic pop;
  logic full;
  logic do_push;
  logic drop;

`ifdef GPIO_EDGE_DETECT_EN
  logic we_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) we_q <= 1'b0;
    else     we_q <= we_gpio_i;
  end

  assign push_req = we_gpio_i & ~we_q;
`else
  assign push_req = we_gpio_i;
`endif

  assign full = (count == CNT_W'(FIFO_DEPTH));
  // The count check is redundant, because LOAD is only entered with
  // count != 0. It keeps an empty FIFO from ever being popped.
  assign pop     = (state == S_LOAD) && (count != '0);
  // While full, a push can still go through if a pop frees a slot
  // at the same edge.
  assign do_push = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  // The storage array is not reset. Clearing the pointers and the count
  // is enough to discard its contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= gpio_i;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)                overflow_o <= 1'b1;
      else if (clr_overflow_i) overflow_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      tmr         <= '0;
      led_o       <= '0;
      led_valid_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count != '0) state <= S_LOAD;
        end
        S_LOAD: begin
          led_o       <= mem[rd_ptr];
          led_valid_o <= 1'b1;
          tmr         <= TMR_W'(HOLD_CYCLES - 1);
          state       <= S_HOLD;
        end
        S_HOLD: begin
          if (tmr != '0) tmr <= tmr - 1'b1;
          else if (count != '0) state <= S_LOAD;
          else state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = (state != S_IDLE);
  assign fifo_count_o = count;

endmodule

// File: tb/tb_gpio_out_ctrl.sv
// tb_gpio_out_ctrl
//   Directed bench for gpio_out_ctrl with HOLD_CYCLES=4, FIFO_DEPTH=4 and
//   DATA_WIDTH=32. The level-sensitive burst and overflow sequence runs when
//   GPIO_EDGE_DETECT_EN is undefined. The held-strobe sequence runs when it
//   is defined. Inputs are driven and outputs sampled 1 time unit after each
//   rising edge. Edge numbering E0, E1, ... follows the first push edge of
//   each sequence.
module tb_gpio_out_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] gpio_i = '0;
  logic        we_gpio_i = 1'b0;
  logic        clr_overflow_i = 1'b0;
  logic [31:0] led_o;
  logic        led_valid_o;
  logic [2:0]  fifo_count_o;
  logic        overflow_o;
  logic        busy_o;

  int n_pass  = 0;
  int n_total = 0;

  gpio_out_ctrl #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4),
    .HOLD_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .gpio_i        (gpio_i),
    .we_gpio_i     (we_gpio_i),
    .clr_overflow_i(clr_overflow_i),
    .led_o         (led_o),
    .led_valid_o   (led_valid_o),
    .fifo_count_o  (fifo_count_o),
    .overflow_o    (overflow_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_led"},   led_o, 32'h0);
    chk({tag, "_valid"}, 32'(led_valid_o), 32'd0);
    chk({tag, "_count"}, 32'(fifo_count_o), 32'd0);
    chk({tag, "_ovf"},   32'(overflow_o), 32'd0);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
  endtask

  initial begin
    // Reset held for 3 cycles.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_idle_zero("reset");

    // Single 1-cycle write of 0xA5.
    gpio_i = 32'hA5; we_gpio_i = 1'b1;
    tick();                                   // E0
    we_gpio_i = 1'b0; gpio_i = '0;
    chk("single_e0_count", 32'(fifo_count_o), 32'd1);
    chk("single_e0_busy",  32'(busy_o), 32'd0);
    tick();                                   // E1
    chk("single_e1_busy", 32'(busy_o), 32'd1);
    chk("single_e1_led",  led_o, 32'h0);
    tick();                                   // E2
    chk("single_e2_led",   led_o, 32'hA5);
    chk("single_e2_valid", 32'(led_valid_o), 32'd1);
    chk("single_e2_count", 32'(fifo_count_o), 32'd0);
    repeat (3) tick();                        // E5
    chk("single_e5_busy", 32'(busy_o), 32'd1);
    tick();                                   // E6
    chk("single_e6_busy",  32'(busy_o), 32'd0);
    chk("single_e6_count", 32'(fifo_count_o), 32'd0);
    chk("single_e6_led",   led_o, 32'hA5);

`ifndef GPIO_EDGE_DETECT_EN
    // Burst of writes 1..6 on consecutive edges. The 6th is dropped.
    // Then a clear that coincides with another drop, then a clear alone.
    gpio_i = 32'd1; we_gpio_i = 1'b1;
    tick();                                   // E0
    gpio_i = 32'd2;
    chk("burst_e0_count", 32'(fifo_count_o), 32'd1);
    tick();                                   // E1
    gpio_i = 32'd3;
    chk("burst_e1_busy", 32'(busy_o), 32'd1);
    tick();                                   // E2 (pop 1, push 3)
    gpio_i = 32'd4;
    chk("burst_e2_led",   led_o, 32'd1);
    chk("burst_e2_count", 32'(fifo_count_o), 32'd2);
    tick();                                   // E3
    gpio_i = 32'd5;
    tick();                                   // E4
    gpio_i = 32'd6;
    chk("burst_e4_count", 32'(fifo_count_o), 32'd4);
    chk("burst_e4_ovf",   32'(overflow_o), 32'd0);
    tick();                                   // E5 (6 dropped)
    gpio_i = 32'd7; clr_overflow_i = 1'b1;
    chk("burst_e5_ovf",   32'(overflow_o), 32'd1);
    chk("burst_e5_count", 32'(fifo_count_o), 32'd4);
    chk("burst_e5_led",   led_o, 32'd1);
    tick();                                   // E6 (7 dropped while clr high)
    we_gpio_i = 1'b0; gpio_i = '0;
    chk("clr_vs_drop_ovf", 32'(overflow_o), 32'd1);
    chk("clr_vs_drop_count", 32'(fifo_count_o), 32'd4);
    chk("burst_e6_led",    led_o, 32'd1);
    tick();                                   // E7 (clear alone, pop 2)
    clr_overflow_i = 1'b0;
    chk("clr_alone_ovf", 32'(overflow_o), 32'd0);
    chk("burst_e7_count", 32'(fifo_count_o), 32'd3);
    // Values 2..5 each shown for exactly 5 cycles, starting at E7.
    for (int v = 2; v <= 5; v++) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("burst_hold_v%0d_k%0d", v, k), led_o, 32'(v));
        tick();
      end
    end
    chk("burst_end_busy",  32'(busy_o), 32'd0);
    chk("burst_end_count", 32'(fifo_count_o), 32'd0);
    chk("burst_end_led",   led_o, 32'd5);
    chk("burst_end_valid", 32'(led_valid_o), 32'd1);
`else
    // Strobe held high for 10 cycles gives exactly one push.
    gpio_i = 32'h3; we_gpio_i = 1'b1;
    tick();                                   // E0
    chk("held_e0_count", 32'(fifo_count_o), 32'd1);
    tick();                                   // E1
    chk("held_e1_count", 32'(fifo_count_o), 32'd1);
    tick();                                   // E2
    chk("held_e2_led",   led_o, 32'h3);
    chk("held_e2_count", 32'(fifo_count_o), 32'd0);
    repeat (7) tick();                        // E9, strobe still high
    we_gpio_i = 1'b0; gpio_i = '0;
    chk("held_e9_count", 32'(fifo_count_o), 32'd0);
    chk("held_e9_busy",  32'(busy_o), 32'd0);
    repeat (3) tick();
    chk("held_end_led",   led_o, 32'h3);
    chk("held_end_ovf",   32'(overflow_o), 32'd0);
    chk("held_end_count", 32'(fifo_count_o), 32'd0);
    chk("held_end_busy",  32'(busy_o), 32'd0);
`endif

    // Writes at E0, E2 and E4, each a 1-cycle pulse. After E4, A is in
    // HOLD and B, C are buffered. Then reset lands mid-HOLD.
    gpio_i = 32'h11; we_gpio_i = 1'b1;
    tick();                                   // E0
    we_gpio_i = 1'b0;
    tick();                                   // E1
    gpio_i = 32'h22; we_gpio_i = 1'b1;
    tick();                                   // E2
    we_gpio_i = 1'b0;
    chk("rst_pre_led", led_o, 32'h11);
    tick();                                   // E3
    gpio_i = 32'h33; we_gpio_i = 1'b1;
    tick();                                   // E4
    we_gpio_i = 1'b0; gpio_i = '0;
    chk("rst_pre_count", 32'(fifo_count_o), 32'd2);
    chk("rst_pre_busy",  32'(busy_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_zero("rst_async");
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk_idle_zero("rst_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
